// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each grant carries a burst of up to MAX_BURST words. Bursts are separated by one idle cycle.

module fifo_wr_arbiter_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic                  busy,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  gnt,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] data
);
  always_comb begin
    gnt  = busy & sel;
    ack  = wr & sel;
    data = ack ? wdata : '0;
  end
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               ack,
  input  logic                             fifo_full,
  output logic                             fifo_wr,
  output logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       owner
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]   pick;
  logic            found;
  logic            wr;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_arr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;

  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return OW'(s);
  endfunction

  assign wdata_arr = wdata;
  assign busy      = (state_q == BURST);
  assign wr        = busy && req[owner_q] && !fifo_full;
  assign fifo_wr   = wr;
  assign owner     = owner_q;

  // Per-producer grant/ack decode and data masking; the masked slices are OR-merged below.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel   (owner_q == OW'(i)),
      .busy  (busy),
      .wr    (wr),
      .wdata (wdata_arr[i]),
      .gnt   (gnt[i]),
      .ack   (ack[i]),
      .data  (lane_data[i])
    );
  end

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) fifo_data = fifo_data | lane_data[i];
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[wrap_add(rr_ptr_q, k)]) begin
        pick  = wrap_add(rr_ptr_q, k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BURST;
          owner_d    = pick;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (wr) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last[owner_q] || beat_cnt_q == BW'(MAX_BURST - 1)) begin
            state_d    = IDLE;
            rr_ptr_d   = wrap_add(owner_q, 1);
            beat_cnt_d = '0;
          end
        end else if (!req[owner_q]) begin
          state_d    = IDLE;
          rr_ptr_d   = wrap_add(owner_q, 1);
          beat_cnt_d = '0;
        end
        // otherwise a full stall: everything holds
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of grant order, burst limits and FIFO back-pressure.

module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req, last;
  logic [N*DW-1:0]   wdata;
  logic              fifo_full;
  logic [N-1:0]      gnt, ack;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_data;
  logic              busy;
  logic [1:0]        owner;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .last(last), .wdata(wdata),
    .gnt(gnt), .ack(ack), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic do_reset();
    reset_n = 1'b0; req = '0; last = '0; wdata = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; req = 4'hF; last = '0; wdata = '1; fifo_full = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt, ack, fifo_wr, busy, owner} !== '0 || fifo_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%h ack=%h wr=%b busy=%b owner=%0d data=%h expected all zero",
               gnt, ack, fifo_wr, busy, owner, fifo_data);
    end
    do_reset();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0 || gnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_release busy=%b owner=%0d gnt=%h expected 0/0/0", busy, owner, gnt);
    end
  endtask

  task automatic test_single_producer();
    do_reset();
    req = 4'b0100; wdata[2*DW +: DW] = 32'hA0;
    @(negedge clock);
    checks++;
    if (gnt !== 4'h0 || fifo_wr !== 1'b0) begin
      errors++;
      $display("FAIL single_idle gnt=%h wr=%b expected 0/0", gnt, fifo_wr);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      wdata[2*DW +: DW] = 32'hA0 + 32'(k);
      last = (k == 2) ? 4'b0100 : 4'b0000;
      @(negedge clock);
      checks++;
      if (gnt !== 4'b0100 || ack !== 4'b0100 || fifo_wr !== 1'b1 || fifo_data !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL single_beat%0d gnt=%h ack=%h wr=%b data=%h expected 4/4/1/%h",
                 k, gnt, ack, fifo_wr, fifo_data, 32'hA0 + 32'(k));
      end
    end
    next_cycle();
    req = '0; last = '0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || owner !== 2'd2 || fifo_wr !== 1'b0) begin
      errors++;
      $display("FAIL single_release busy=%b owner=%0d wr=%b expected 0/2/0", busy, owner, fifo_wr);
    end
  endtask

  task automatic test_round_robin();
    int cnt[N];
    logic [N-1:0] eg;
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    req = 4'hF;
    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < N; i++) last[i] = cnt[i][0];
      eg = (k % 3 == 0) ? 4'h0 : 4'(1 << ((k / 3) % N));
      @(negedge clock);
      checks++;
      if (gnt !== eg || ack !== eg) begin
        errors++;
        $display("FAIL rr_cycle%0d gnt=%h ack=%h expected %h", k, gnt, ack, eg);
      end
      for (int i = 0; i < N; i++) if (eg[i]) cnt[i]++;
      next_cycle();
    end
    req = '0;
  endtask

  task automatic test_forced_release();
    int eg[10] = '{0, 2, 2, 2, 2, 0, 1, 0, 2, 2};
    int ed[10] = '{0, 'h100, 'h101, 'h102, 'h103, 0, 'h55, 0, 'h104, 'h105};
    int seq1 = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req = {2'b00, 1'b1, (k >= 3 && k <= 6)};
      last = 4'b0001;
      wdata[0 +: DW] = 32'h55;
      wdata[DW +: DW] = 32'h100 + 32'(seq1);
      @(negedge clock);
      checks++;
      if (gnt !== 4'(eg[k]) || fifo_data !== 32'(ed[k])) begin
        errors++;
        $display("FAIL forced_cycle%0d gnt=%h data=%h expected %h/%h", k, gnt, fifo_data, eg[k], ed[k]);
      end
      if (eg[k] == 2) seq1++;
      next_cycle();
    end
    req = '0; last = '0;
  endtask

  task automatic test_full_stall();
    int ew[9] = '{0, 1, 0, 0, 0, 1, 1, 1, 0};
    int eg[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int seq = 0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      req = 4'b0001; last = '0;
      fifo_full = (k >= 2 && k <= 4);
      wdata[0 +: DW] = 32'hB0 + 32'(seq);
      @(negedge clock);
      checks++;
      if (fifo_wr !== ew[k][0] || gnt !== 4'(eg[k]) || ack !== 4'(ew[k]) ||
          fifo_data !== (ew[k] != 0 ? 32'hB0 + 32'(seq) : 32'h0)) begin
        errors++;
        $display("FAIL stall_cycle%0d wr=%b gnt=%h ack=%h data=%h expected wr=%0d gnt=%0d seq=%0d",
                 k, fifo_wr, gnt, ack, fifo_data, ew[k], eg[k], seq);
      end
      if (ew[k] != 0) seq++;
      next_cycle();
    end
    req = '0; fifo_full = 1'b0;
  endtask

  task automatic test_withdraw();
    int rq[5] = '{8, 8, 2, 2, 2};
    int eg[5] = '{0, 8, 8, 0, 2};
    int ew[5] = '{0, 1, 0, 0, 1};
    do_reset();
    wdata[3*DW +: DW] = 32'hC0;
    wdata[1*DW +: DW] = 32'hC1;
    for (int k = 0; k < 5; k++) begin
      req = 4'(rq[k]); last = '0;
      @(negedge clock);
      checks++;
      if (gnt !== 4'(eg[k]) || fifo_wr !== ew[k][0] ||
          fifo_data !== (k == 1 ? 32'hC0 : (k == 4 ? 32'hC1 : 32'h0))) begin
        errors++;
        $display("FAIL withdraw_cycle%0d gnt=%h wr=%b data=%h expected gnt=%0d wr=%0d",
                 k, gnt, fifo_wr, fifo_data, eg[k], ew[k]);
      end
      next_cycle();
    end
    req = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0100; wdata[2*DW +: DW] = 32'hD0;
    next_cycle();
    @(negedge clock);
    checks++;
    if (fifo_wr !== 1'b1 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_pre wr=%b gnt=%h expected 1/4", fifo_wr, gnt);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'h0 || ack !== 4'h0 || fifo_wr !== 1'b0 || busy !== 1'b0 ||
        owner !== 2'd0 || fifo_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async gnt=%h ack=%h wr=%b busy=%b owner=%0d data=%h expected all zero",
               gnt, ack, fifo_wr, busy, owner, fifo_data);
    end
    #1 reset_n = 1'b1;
    req = 4'b0101;
    next_cycle();
    @(negedge clock);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_regrant gnt=%h expected 1", gnt);
    end
    next_cycle();
    req = '0;
  endtask

  task automatic test_random();
    int seq[N];
    bit m_busy = 0;
    int m_own = 0, m_ptr = 0, m_beats = 0;
    logic [N-1:0] eg, ea;
    logic ew;
    logic [DW-1:0] ed;
    do_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 3) != 0);
        last[i] = ($urandom_range(0, 3) == 0);
        wdata[i*DW +: DW] = {8'(i), 24'(seq[i])};
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      ew = m_busy && req[m_own] && !fifo_full;
      eg = m_busy ? 4'(1 << m_own) : 4'h0;
      ea = ew ? eg : 4'h0;
      ed = ew ? {8'(m_own), 24'(seq[m_own])} : 32'h0;
      checks++;
      if (gnt !== eg || ack !== ea || fifo_wr !== ew || fifo_data !== ed) begin
        errors++;
        $display("FAIL rand_c%0d gnt=%h ack=%h wr=%b data=%h expected %h/%h/%b/%h",
                 c, gnt, ack, fifo_wr, fifo_data, eg, ea, ew, ed);
      end
      checks++;
      if (busy !== m_busy || owner !== 2'(m_own) || (fifo_wr && fifo_full)) begin
        errors++;
        $display("FAIL rand_state_c%0d busy=%b owner=%0d wr=%b full=%b expected busy=%b owner=%0d",
                 c, busy, owner, fifo_wr, fifo_full, m_busy, m_own);
      end
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          if (!m_busy && req[(m_ptr + k) % N]) begin
            m_own = (m_ptr + k) % N; m_busy = 1; m_beats = 0;
          end
        end
      end else if (ew) begin
        seq[m_own]++;
        m_beats++;
        if (last[m_own] || m_beats == MB) begin
          m_busy = 0; m_ptr = (m_own + 1) % N; m_beats = 0;
        end
      end else if (!req[m_own]) begin
        m_busy = 0; m_ptr = (m_own + 1) % N; m_beats = 0;
      end
      next_cycle();
    end
    req = '0; fifo_full = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; req = '0; last = '0; wdata = '0; fifo_full = 1'b0;
    test_reset();
    test_single_producer();
    test_round_robin();
    test_forced_release();
    test_full_stall();
    test_withdraw();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the 32-bit FIFO write port among NUM_REQ producers.
- Each producer requests, is granted, and transfers a burst of up to MAX_BURST words terminated by its last flag.
- The arbiter drives the FIFO wr/data_in pins, observes FIFO full, and never issues a write the FIFO would reject.

Parameters:
- NUM_REQ, 4, number of requesting producers (2..8).
- DATA_WIDTH, 32, word width; matches the FIFO data width.
- MAX_BURST, 4, maximum words per grant before forced release (1..16).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-producer request; held high while the producer has a word presented.
- last  in  NUM_REQ  per-producer end-of-burst flag, qualified by the accepted word.
- wdata  in  NUM_REQ*DATA_WIDTH  concatenated producer words; slice i = wdata[i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot grant; all zeros when idle.
- ack  out  NUM_REQ  one-hot word-accepted strobe; producer i advances its word when ack[i]=1.
- fifo_full  in  1  FIFO full status.
- fifo_wr  out  1  FIFO write strobe.
- fifo_data  out  DATA_WIDTH  FIFO write data.
- busy  out  1  high while in BURST.
- owner  out  $clog2(NUM_REQ)  index of current or last grantee.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. On reset_n=0, immediately:
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - Outputs: gnt=0, ack=0, fifo_wr=0, busy=0, fifo_data=0.
- Registered state: state (IDLE/BURST), owner, rr_ptr, beat_cnt (width $clog2(MAX_BURST)+1).
- Outputs are combinational from registered state plus inputs:
  - gnt = (state==BURST) ? onehot(owner) : 0.
  - fifo_wr = (state==BURST) && req[owner] && !fifo_full.
  - ack = fifo_wr ? onehot(owner) : 0.
  - fifo_data = fifo_wr ? wdata slice[owner] : 0.
  - busy = (state==BURST).
- IDLE:
  - If any req bit is set, pick the first index at or after rr_ptr, scanning upward modulo NUM_REQ.
  - Next edge: owner<=pick, beat_cnt<=0, state<=BURST.
  - No write occurs in IDLE. Minimum latency from req to first fifo_wr is 1 cycle.
- BURST, each edge:
  - If fifo_wr: beat_cnt<=beat_cnt+1. If last[owner]=1 or beat_cnt==MAX_BURST-1, release.
  - Else if req[owner]=0 (producer withdrew): release; no word counted.
  - Else (fifo_full stall): hold state, owner and beat_cnt. The grant stays with the owner indefinitely while full persists.
- Release: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ, beat_cnt<=0. owner keeps its value.
- One idle bubble cycle always separates consecutive bursts, including two bursts by the same producer.
- Fairness: a continuously requesting producer waits at most NUM_REQ-1 bursts.
- Boundary conditions:
  - last and the MAX_BURST limit on the same beat: a single release.
  - fifo_full rising in the same cycle as a pending word: no write, no ack, no count.
  - req bits of non-owners are ignored during BURST.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset mid-burst: the burst is abandoned with no further writes. Producers must treat the in-flight word as not accepted (no ack).
- Invariants:
  - gnt and ack are one-hot or zero.
  - ack implies gnt on the same bit.
  - fifo_wr is never high when fifo_full=1.

Test Plan:
- Single producer: req[2]=1 holding 0xA0..0xA2, last on the third word → gnt[2] in cycle 1, writes 0xA0,0xA1,0xA2 in cycles 1-3, release, busy=0 in cycle 4.
- All four requesting from reset, 2-word bursts each → grant order 0,1,2,3,0; one idle cycle between bursts; rr_ptr wraps to 0.
- MAX_BURST=4 with req[1] streaming 10 words and last never asserted → forced release after 4 writes. If req[0] also requests, it is served next; then req[1] resumes.
- fifo_full high for 3 cycles mid-burst → fifo_wr=0 and ack=0 for those cycles, gnt holds, beat_cnt frozen, burst completes with exact word order.
- req[3] drops after 1 of an intended 3 words → release the next cycle; only 1 write issued; the next requester is granted.
- reset_n pulsed low asynchronously mid-burst (between clock edges) → gnt, fifo_wr and ack go to 0 immediately; after release the first grant goes to index 0 per rr_ptr=0.
